// File: rtl/ama_riscv_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package ama_riscv_dmem_arbiter_pkg;

    // Arbiter states: IDLE (no refusal pending), WAIT (secondary refused
    // at least once), FORCE (one-cycle forced secondary grant).
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

    // Width of the refusal counter. It never wraps because it stops at
    // MAX_WAIT, which is limited to 1..255.
    localparam int WAIT_CNT_W = 8;

    // Bytes written by a secondary access; zero means a read.
    function automatic logic is_read(input logic [3:0] we);
        return (we == 4'b0000);
    endfunction

endpackage

// File: rtl/ama_riscv_dmem_arbiter.sv
// Data-memory arbiter: the core MEM stage has fixed priority over a
// secondary (debug/loader) port. The secondary is served in idle memory
// cycles. After MAX_WAIT refusals the core is stalled for one cycle so the
// secondary can get through.
module ama_riscv_dmem_arbiter
    import ama_riscv_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    // core MEM-stage access
    input  logic              core_en,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              stall_core,
    // secondary requester
    input  logic              sec_req,
    input  logic [3:0]        sec_we,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [31:0]       sec_wdata,
    output logic              sec_gnt,
    output logic              sec_rvalid,
    output logic [31:0]       sec_rdata,
    // data memory macro
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt_inc;

    // Next-state, refusal counting, and grant/stall decision.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        wait_cnt_inc = wait_cnt + WAIT_CNT_W'(1);
        stall_core   = 1'b0;
        sec_gnt      = 1'b0;

        case (state)
            ARB_IDLE, ARB_WAIT: begin
                sec_gnt = sec_req & ~core_en;
                if (sec_req && core_en) begin
                    // Refused: count it and force a grant once the limit is hit.
                    wait_cnt_nxt = wait_cnt_inc;
                    state_nxt    = (wait_cnt_inc == MAX_WAIT_C) ? ARB_FORCE : ARB_WAIT;
                end else begin
                    // Granted, or the request went away: start over.
                    wait_cnt_nxt = '0;
                    state_nxt    = ARB_IDLE;
                end
            end
            ARB_FORCE: begin
                // Core holds its access and re-presents it next cycle.
                stall_core   = 1'b1;
                sec_gnt      = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ARB_IDLE;
            end
            default: begin
                wait_cnt_nxt = '0;
                state_nxt    = ARB_IDLE;
            end
        endcase

        // Nothing is granted and nothing is stalled while in reset.
        if (rst) begin
            stall_core = 1'b0;
            sec_gnt    = 1'b0;
        end
    end

    // Memory port mux: the secondary drives memory only when granted.
    // Otherwise core fields stay on the bus even when idle, so the address
    // and data lines do not toggle.
    always_comb begin
        if (sec_gnt) begin
            mem_en    = 1'b1;
            mem_we    = sec_we;
            mem_addr  = sec_addr;
            mem_wdata = sec_wdata;
        end else begin
            mem_en    = core_en;
            mem_we    = core_en ? core_we : 4'b0000;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // Read data returns one cycle after issue with no extra buffering.
    assign sec_rdata = mem_rdata;

    // State, refusal counter, and secondary read-valid registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (rst) begin
            state      <= ARB_IDLE;
            wait_cnt   <= '0;
            sec_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            sec_rvalid <= sec_gnt & is_read(sec_we);
        end
    end

endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
// Scoreboard bench for the data-memory arbiter. Each stimulus cycle pushes
// its hand-derived expectation. A negedge monitor pops the entry and
// compares it against the DUT outputs. A second instance with MAX_WAIT = 1
// shares the same inputs and is checked only on the vectors that flag it.
module tb_ama_riscv_dmem_arbiter;

    localparam int ADDR_W = 14;

    typedef struct {
        logic              stall;
        logic              gnt;
        logic              mem_en;
        logic [3:0]        mem_we;
        logic [ADDR_W-1:0] mem_addr;
        logic [31:0]       mem_wdata;
        logic              rvalid;
        logic [31:0]       rdata;
        logic              chk1;
        logic              stall1;
        logic              gnt1;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              core_en = 1'b0;
    logic [3:0]        core_we = '0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [31:0]       core_wdata = '0;
    logic              sec_req = 1'b0;
    logic [3:0]        sec_we = '0;
    logic [ADDR_W-1:0] sec_addr = '0;
    logic [31:0]       sec_wdata = '0;
    logic [31:0]       mem_rdata = '0;

    logic              stall_core, sec_gnt, sec_rvalid, mem_en;
    logic [31:0]       sec_rdata, mem_wdata;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;

    logic              stall_core1, sec_gnt1, sec_rvalid1, mem_en1;
    logic [31:0]       sec_rdata1, mem_wdata1;
    logic [3:0]        mem_we1;
    logic [ADDR_W-1:0] mem_addr1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ama_riscv_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .stall_core(stall_core),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    ama_riscv_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .stall_core(stall_core1),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_gnt(sec_gnt1), .sec_rvalid(sec_rvalid1), .sec_rdata(sec_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle. Expected stall/grant/rvalid are given by hand, and
    // the expected memory bus follows from which side is granted.
    task automatic cyc(input logic r, input logic cen, input logic [3:0] cwe,
                       input logic [ADDR_W-1:0] caddr, input logic sreq,
                       input logic [3:0] swe, input logic [ADDR_W-1:0] saddr,
                       input logic [31:0] rdata, input logic e_stall, input logic e_gnt,
                       input logic e_rv, input logic chk1 = 1'b0,
                       input logic e_stall1 = 1'b0, input logic e_gnt1 = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        core_en    = cen;
        core_we    = cwe;
        core_addr  = caddr;
        core_wdata = 32'hC0DE_0000 | {18'd0, caddr};
        sec_req    = sreq;
        sec_we     = swe;
        sec_addr   = saddr;
        sec_wdata  = 32'h5EC0_0000 | {18'd0, saddr};
        mem_rdata  = rdata;
        e.stall  = e_stall;
        e.gnt    = e_gnt;
        e.rvalid = e_rv;
        e.rdata  = rdata;
        e.chk1   = chk1;
        e.stall1 = e_stall1;
        e.gnt1   = e_gnt1;
        if (e_gnt) begin
            e.mem_en    = 1'b1;
            e.mem_we    = swe;
            e.mem_addr  = saddr;
            e.mem_wdata = 32'h5EC0_0000 | {18'd0, saddr};
        end else begin
            e.mem_en    = cen;
            e.mem_we    = cen ? cwe : 4'b0000;
            e.mem_addr  = caddr;
            e.mem_wdata = 32'hC0DE_0000 | {18'd0, caddr};
        end
        q.push_back(e);
    endtask

    // Monitor: compare each pushed expectation in the middle of its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("stall_core", 32'(stall_core), 32'(e.stall));
            check("sec_gnt",    32'(sec_gnt),    32'(e.gnt));
            check("mem_en",     32'(mem_en),     32'(e.mem_en));
            check("mem_we",     32'(mem_we),     32'(e.mem_we));
            check("mem_addr",   32'(mem_addr),   32'(e.mem_addr));
            check("mem_wdata",  mem_wdata,       e.mem_wdata);
            check("sec_rvalid", 32'(sec_rvalid), 32'(e.rvalid));
            if (e.rvalid)
                check("sec_rdata", sec_rdata, e.rdata);
            if (e.chk1) begin
                check("stall_core_mw1", 32'(stall_core1), 32'(e.stall1));
                check("sec_gnt_mw1",    32'(sec_gnt1),    32'(e.gnt1));
            end
        end
    end

    initial begin
        // Reset with a secondary request present: no grant, no stall.
        cyc(1, 0, 4'h0, 14'h000, 1, 4'h0, 14'h010, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 4'h0, 14'h000, 1, 4'h0, 14'h010, 0, 0, 0, 0, 1, 0, 0);

        // Idle core: secondary read granted at once, data valid next cycle.
        cyc(0, 0, 4'h0, 14'h000, 1, 4'h0, 14'h010, 0, 0, 1, 0, 1, 0, 1);
        cyc(0, 0, 4'h0, 14'h001, 0, 4'h0, 14'h000, 32'hDEAD_BEEF, 0, 0, 1);

        // Continuous core traffic: secondary write forced through in cycle 8.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 4'h3, 14'(14'h100 + i), 1, 4'hF, 14'h020, 0, 0, 0, 0);
        cyc(0, 1, 4'h3, 14'h108, 1, 4'hF, 14'h020, 0, 1, 1, 0);
        cyc(0, 1, 4'h3, 14'h109, 0, 4'h0, 14'h000, 0, 0, 0, 0);

        // Core 1,1,0 with read held: grant at cycle 2, never a stall.
        cyc(0, 1, 4'h0, 14'h200, 1, 4'h0, 14'h030, 0, 0, 0, 0);
        cyc(0, 1, 4'h0, 14'h201, 1, 4'h0, 14'h030, 0, 0, 0, 0);
        cyc(0, 0, 4'h0, 14'h202, 1, 4'h0, 14'h030, 0, 0, 1, 0);
        // A fresh request right after the grant needs the full eight refusals.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 4'h0, 14'(14'h210 + i), 1, 4'h1, 14'h031,
                (i == 0) ? 32'h1234_5678 : 32'h0, 0, 0, (i == 0));
        cyc(0, 1, 4'h0, 14'h218, 1, 4'h1, 14'h031, 0, 1, 1, 0);
        cyc(0, 1, 4'h0, 14'h219, 0, 4'h0, 14'h000, 0, 0, 0, 0);

        // Core write and secondary read collide: core wins, no rvalid.
        cyc(0, 1, 4'hF, 14'h040, 1, 4'h0, 14'h041, 0, 0, 0, 0);
        cyc(0, 0, 4'h0, 14'h042, 0, 4'h0, 14'h000, 32'hAAAA_5555, 0, 0, 0);

        // Reset during the FORCE cycle: no grant, no stall, back to IDLE.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 4'h7, 14'(14'h300 + i), 1, 4'h0, 14'h050, 0, 0, 0, 0);
        cyc(1, 1, 4'h7, 14'h308, 1, 4'h0, 14'h050, 0, 0, 0, 0);
        cyc(0, 1, 4'h7, 14'h309, 1, 4'h0, 14'h050, 32'h0BAD_0BAD, 0, 0, 0);
        cyc(0, 0, 4'h0, 14'h30A, 0, 4'h0, 14'h000, 0, 0, 0, 0);

        // Request dropped after 3 refusals: counter restarts from zero.
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 4'h2, 14'(14'h400 + i), 1, 4'h0, 14'h060, 0, 0, 0, 0);
        cyc(0, 1, 4'h2, 14'h403, 0, 4'h0, 14'h000, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 4'h2, 14'(14'h410 + i), 1, 4'h0, 14'h061, 0, 0, 0, 0);
        cyc(0, 1, 4'h2, 14'h418, 1, 4'h0, 14'h061, 0, 1, 1, 0);
        cyc(0, 1, 4'h2, 14'h419, 0, 4'h0, 14'h000, 32'hCAFE_F00D, 0, 0, 1);

        // MAX_WAIT = 1: one refusal, FORCE in the next cycle.
        cyc(0, 0, 4'h0, 14'h4FF, 0, 4'h0, 14'h000, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 4'h1, 14'h500, 1, 4'hF, 14'h070, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 4'h1, 14'h501, 1, 4'hF, 14'h070, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 4'h0, 14'h502, 0, 4'h0, 14'h000, 0, 0, 0, 0, 1, 0, 0);

        // Fully idle: mem_en and mem_we low, core address/data held on bus.
        cyc(0, 0, 4'h5, 14'h3AB, 0, 4'h0, 14'h000, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
